// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock glitch filter,
// falling-edge bit capture, frame checking and an inter-edge timeout.
module ps2_frame_receiver #(
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT_US   = 200
) (
    input  logic        clock,
    input  logic        clock_sreset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic        data_valid,
    output logic [10:0] data_out,
    output logic        parity_error,
    output logic        frame_error,
    output logic        busy
);

    localparam int TIMEOUT_CYCLES = SYSTEM_CLOCK / 1000000 * TIMEOUT_US;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam logic [TW-1:0]  TMO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic            clk_filt_q, clk_filt_d;
    logic            clk_prev_q, clk_prev_d;
    logic [FCW-1:0]  filt_cnt_q, filt_cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [10:0]     shift_q, shift_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [10:0]     data_out_q, data_out_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;

    logic            fall;
    logic            bit_in;
    logic            timeout;

    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            state_q    <= ST_IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_filt_q <= 1'b1;
            clk_prev_q <= 1'b1;
            filt_cnt_q <= '0;
            tmr_q      <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            clk_filt_q <= clk_filt_d;
            clk_prev_q <= clk_prev_d;
            filt_cnt_q <= filt_cnt_d;
            tmr_q      <= tmr_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Synchronisers and clock filter: the filtered clock follows only a level
    // that has been stable for FILTER_LEN consecutive samples.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_dat;
        dat_s2_d   = dat_s1_q;
        clk_prev_d = clk_filt_q;
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                clk_filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall    = clk_prev_q & ~clk_filt_q;
    assign bit_in  = dat_s2_q;
    assign timeout = (tmr_q == TMO_MAX);

    always_comb begin
        tmr_d = tmr_q;
        if (fall || (state_q == ST_IDLE)) begin
            tmr_d = '0;
        end else if (!timeout) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall && !bit_in) begin
                    shift_d  = '0;
                    bitcnt_d = 4'd1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    shift_d[bitcnt_q] = bit_in;
                    bitcnt_d          = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd10) begin
                        state_d = ST_CHECK;
                    end
                end else if (timeout) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // Parity takes precedence over the stop bit.
                if (^shift_q[9:1] != 1'b1) begin
                    perr_d = 1'b1;
                end else if (!shift_q[10]) begin
                    ferr_d = 1'b1;
                end else begin
                    data_out_d = shift_q;
                    valid_d    = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_valid   = valid_q;
    assign parity_error = perr_q;
    assign frame_error  = ferr_q;
    assign data_out     = data_out_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
